// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the transmit and receive paths
// Holds the serial FSM state encoding, the data width of a character and the
// default bit period used by uart_tx and the future uart_rx.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS            = 8;
    // 50 MHz system clock / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/baud_tick.sv
// rtl/baud_tick.sv - bit-period counter producing a one-cycle bit-boundary tick
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset, clears the counter
//   run    : 1 = count, 0 = hold the counter cleared at zero
//   tick   : high for the last cycle of each CLKS_PER_BIT-cycle bit period
module baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // The tick marks the final cycle of a bit so the owner changes bit on the
    // same edge that reloads the counter to zero.
    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with registered channel-select outputs
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-high reset, aborts any frame in flight
//   tx_data  : byte to send, sampled on acceptance (tx_valid && tx_ready)
//   tx_valid : producer offers tx_data / ch_sel
//   ch_sel   : destination channel, latched onto {s1,s0} on acceptance
//   tx_ready : high only while idle
//   tx       : serial line, idle high, start/8 data LSB first/stop
//   s1, s0   : channel select for the external line selector, stable per frame
//   tx_busy  : high from acceptance until the stop bit completes
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic [1:0] ch_sel,
    output logic       tx_ready,
    output logic       tx,
    output logic       s1,
    output logic       s0,
    output logic       tx_busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t state, state_next;
    logic [7:0]  shift_reg, shift_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic        tx_next, ready_next, busy_next;
    logic [1:0]  sel_next;
    logic        bit_tick;
    logic        baud_run;

    // The counter runs in every non-idle state; it is held at zero while idle
    // so the start bit of an accepted byte always gets a full bit period.
    assign baud_run = (state != IDLE);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .run   (baud_run),
        .tick  (bit_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            s1        <= 1'b0;
            s0        <= 1'b0;
            shift_reg <= '0;
            bit_idx   <= '0;
        end else begin
            state     <= state_next;
            tx        <= tx_next;
            tx_ready  <= ready_next;
            tx_busy   <= busy_next;
            {s1, s0}  <= sel_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_idx_next;
        end
    end

    // Outputs are computed one step ahead so the registered line changes on
    // the same edge as the state it belongs to.
    always_comb begin
        state_next   = state;
        tx_next      = tx;
        ready_next   = tx_ready;
        busy_next    = tx_busy;
        sel_next     = {s1, s0};
        shift_next   = shift_reg;
        bit_idx_next = bit_idx;

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_next = START;
                    shift_next = tx_data;
                    sel_next   = ch_sel;
                    tx_next    = 1'b0;
                    ready_next = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_next   = DATA;
                    tx_next      = shift_reg[0];
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    // Bit 0 is on the line; shift so the next bit sits at [0].
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == LAST_BIT) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        tx_next    = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 tx_data  input  8  byte to transmit; sampled only on acceptance.
REQ-005 tx_valid  input  1  producer has a byte on tx_data.
REQ-006 ch_sel  input  2  target UART channel for this byte; sampled only on acceptance.
REQ-007 tx_ready  output  1  block can accept a byte this cycle.
REQ-008 tx  output  1  serial line, idle high, 8N1 framing; drives tx2 of the channel selector.
REQ-009 s1, s0  output  1 each  registered channel select for the selector's decoder, {s1,s0} = latched ch_sel.
REQ-010 tx_busy  output  1  high from acceptance until the stop bit completes.

Function
REQ-011 The block SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-012 Acceptance SHALL occur on a rising edge where tx_valid=1 and tx_ready=1.
REQ-013 tx_ready SHALL be 1 only in IDLE.
REQ-014 On acceptance, the block SHALL latch tx_data into the shift register and ch_sel into {s1,s0}, and SHALL move to START.
REQ-015 {s1,s0} SHALL change only on acceptance, never mid-frame, so the selector cannot switch during a frame.
REQ-016 tx SHALL go low on the edge after acceptance (1-cycle latency) and SHALL stay low for CLKS_PER_BIT cycles.
REQ-017 DATA SHALL shift out 8 bits LSB first, each held for exactly CLKS_PER_BIT cycles, using a 3-bit bit index that wraps 7->0 on exit.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles and then return to IDLE.
REQ-019 A frame SHALL occupy exactly 10*CLKS_PER_BIT cycles of tx.
REQ-020 The baud counter SHALL count 0..CLKS_PER_BIT-1, reload to 0 at each bit boundary, and be $clog2(CLKS_PER_BIT) bits wide.
REQ-021 The IDLE-to-IDLE minimum inter-frame gap SHALL be 1 cycle; with tx_valid held high, the next byte is accepted on the first IDLE cycle.
REQ-022 tx_valid asserted while not in IDLE SHALL be ignored (no acceptance, no corruption); the producer holds tx_valid and tx_data until tx_ready.
REQ-023 Changes on tx_data or ch_sel after acceptance SHALL NOT affect the frame in flight.
REQ-024 tx, tx_ready, tx_busy, s1 and s0 SHALL be driven from registers (glitch-free).

Reset
REQ-025 Assertion of reset SHALL immediately force: state IDLE, tx=1, tx_ready=1, tx_busy=0, {s1,s0}=00, baud counter 0, bit index 0, shift register 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with tx high at once; no partial frame resumes after release.
REQ-027 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state enum (IDLE, START, DATA, STOP), DATA_BITS=8 and the default CLKS_PER_BIT; the future uart_rx uses the same package.
REQ-029 One sub-module, baud_tick, SHALL hold the CLKS_PER_BIT counter; inputs clk, reset and a run/clear signal, output a 1-cycle bit-boundary tick.
REQ-030 Everything else, including the FSM and shift register, SHALL be in uart_tx.

Verification (CLKS_PER_BIT=4)
REQ-031 Send 0x55 on ch_sel=2 -> tx=1,0,1,0,1,0,1,0,1 after the start bit: start 0, data 1,0,1,0,1,0,1,0, stop 1, each 4 cycles, 40 cycles total; {s1,s0}=10 from acceptance+1; tx_ready returns 1 at cycle 41.
REQ-032 Send 0x00, then 0xFF with tx_valid held high -> second start bit begins exactly 1 idle cycle after the first stop bit ends; bits correct; tx_busy low for exactly that 1 cycle.
REQ-033 During a 0xA5 frame on ch_sel=1, change tx_data to 0x3C and ch_sel to 3 and pulse tx_valid -> frame still 0xA5 (LSB first 1,0,1,0,0,1,0,1); {s1,s0} stays 01; no extra acceptance.
REQ-034 Assert reset at cycle 17 of a 0x0F frame -> tx=1, tx_ready=1 and {s1,s0}=00 asynchronously, before the next edge; after release, sending 0x81 yields a clean frame.
REQ-035 Send bytes on ch_sel 0,1,2,3 in sequence through the channel selector -> each frame appears only on tx3, tx4, tx5, tx6 respectively, and the other lines stay high-Z.
